// File: rtl/integrator_seq_pkg.sv
// rtl/integrator_seq_pkg.sv - shared state encoding and default widths for the integrator filter sequencer
package integrator_seq_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int FILT_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ARM    = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/seq_valid_delay.sv
// rtl/seq_valid_delay.sv - fixed-depth shift register carrying valid and last alongside the filter pipeline
module seq_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] l_q, l_d;

    always_comb begin
        v_d    = v_q;
        l_d    = l_q;
        v_d[0] = in_valid;
        l_d[0] = in_last;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            l_d[i] = l_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_last  = l_q[DEPTH-1];

endmodule

// File: rtl/integrator_filter_sequencer.sv
// rtl/integrator_filter_sequencer.sv - run control for the IIR integrator: flush, settle, arm, stream, drain per waveform
module integrator_filter_sequencer
    import integrator_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = 11,
    parameter int NUM_W      = 16,
    parameter int RST_CYC    = 5,
    parameter int SETTLE_CYC = 5,
    parameter int FILT_LAT   = FILT_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  wf_len,
    input  logic [NUM_W-1:0]  wf_num,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              filt_reset,
    output logic              filt_enable,
    output logic [DATA_W-1:0] filt_x,
    input  logic [DATA_W-1:0] filt_y,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? ((RST_CYC > FILT_LAT) ? RST_CYC : FILT_LAT)
                                                   : ((SETTLE_CYC > FILT_LAT) ? SETTLE_CYC : FILT_LAT);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    seq_state_e        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [LEN_W-1:0]  smp_cnt_q, smp_cnt_d, len_q, len_d;
    logic [NUM_W-1:0]  wf_cnt_q, wf_cnt_d, num_q, num_d;
    logic [DATA_W-1:0] filt_x_q, filt_x_d;
    logic              s_ready_q, s_ready_d;
    logic              filt_reset_q, filt_reset_d;
    logic              filt_enable_q, filt_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              beat_q, beat_d, beat_last_q, beat_last_d;
    logic              accept;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        smp_cnt_d   = smp_cnt_q;
        wf_cnt_d    = wf_cnt_q;
        len_d       = len_q;
        num_d       = num_q;
        filt_x_d    = filt_x_q;
        done_d      = 1'b0;
        beat_last_d = 1'b0;
        accept      = s_valid && s_ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (wf_len != '0 && wf_num != '0) begin
                        state_d   = ST_FLUSH;
                        len_d     = wf_len;
                        num_d     = wf_num;
                        ph_d      = '0;
                        smp_cnt_d = '0;
                        wf_cnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (ph_q == PH_W'(RST_CYC - 1)) begin
                    state_d = ST_SETTLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_SETTLE: begin
                if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_ARM;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_ARM: state_d = ST_STREAM;
            ST_STREAM: begin
                if (accept) begin
                    filt_x_d = s_data;
                    if (smp_cnt_q == len_q - LEN_W'(1)) begin
                        beat_last_d = 1'b1;
                        state_d     = ST_DRAIN;
                        ph_d        = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (ph_q == PH_W'(FILT_LAT - 1)) begin
                    ph_d = '0;
                    if (wf_cnt_q == num_q - NUM_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        wf_cnt_d  = wf_cnt_q + NUM_W'(1);
                        smp_cnt_d = '0;
                        state_d   = ST_FLUSH;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with state_q.
        if (state_d == ST_ARM) begin
            filt_x_d = '0;
        end
        filt_reset_d  = (state_d == ST_FLUSH);
        filt_enable_d = (state_d == ST_ARM) || accept;
        s_ready_d     = (state_d == ST_STREAM);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d        = done_d || (state_d == ST_DONE);
        beat_d        = accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ph_q          <= '0;
            smp_cnt_q     <= '0;
            wf_cnt_q      <= '0;
            len_q         <= '0;
            num_q         <= '0;
            filt_x_q      <= '0;
            s_ready_q     <= 1'b0;
            filt_reset_q  <= 1'b1;
            filt_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            beat_q        <= 1'b0;
            beat_last_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            smp_cnt_q     <= smp_cnt_d;
            wf_cnt_q      <= wf_cnt_d;
            len_q         <= len_d;
            num_q         <= num_d;
            filt_x_q      <= filt_x_d;
            s_ready_q     <= s_ready_d;
            filt_reset_q  <= filt_reset_d;
            filt_enable_q <= filt_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            beat_q        <= beat_d;
            beat_last_q   <= beat_last_d;
        end
    end

    // beat_q marks sample beats on filt_enable; the ARM beat never produces an output.
    seq_valid_delay #(
        .DEPTH (FILT_LAT)
    ) u_valid_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (beat_q),
        .in_last   (beat_last_q),
        .out_valid (m_valid),
        .out_last  (m_last)
    );

    assign m_data      = m_valid ? filt_y : '0;
    assign s_ready     = s_ready_q;
    assign filt_reset  = filt_reset_q;
    assign filt_enable = filt_enable_q;
    assign filt_x      = filt_x_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
